wrr_weight_scheduler: RTL and testbench
=======================================

// Module: wrr_weight_scheduler
// PURPOSE
//  Weighted round-robin grant scheduler for up to 32 requesters. Holds a per-requester
//  4-bit weight table written by the priority-update port (prio/prio_id/prio_upt).
//  Each requester may take up to <weight> consecutive grants per round. Sits between
//  the requester agents and the shared downstream resource; one grant per cycle.
// PARAMETERS
//  NUM_REQ     32  number of requesters (2..32); prio_id values >= NUM_REQ are ignored
//  WEIGHT_W     4  weight/credit width; must equal prio width
//  WEIGHT_RST   1  reset weight and credit of every requester (1 = plain round robin)
// PORTS
//  clk       in   1        clock, all logic on posedge
//  rst       in   1        synchronous reset, active-high
//  req       in   NUM_REQ  level request vector, bit i = requester i
//  prio      in   4        new weight for requester prio_id
//  prio_id   in   5        requester index to update
//  prio_upt  in   1        write strobe: weight[prio_id] <= prio this cycle
//  gnt       out  NUM_REQ  registered one-hot grant, valid with gnt_vld
//  gnt_id    out  5        binary index of gnt
//  gnt_vld   out  1        grant issued this cycle
// BEHAVIOUR
//  - Reset (rst=1 at posedge): weight[*]=credit[*]=WEIGHT_RST, ptr=0, gnt=0, gnt_id=0,
//    gnt_vld=0. Reset mid-burst discards all credit/pointer state; prio_upt ignored.
//  - Eligible(i) = req[i] && weight[i]!=0. Weight 0 masks requester i permanently.
//  - Round reload: if no eligible requester has credit!=0 but some eligible exists,
//    eff_credit = weight for all i (reload) this cycle; else eff_credit = credit.
//    Reload and grant occur in the same cycle: no idle bubble.
//  - Select: first eligible i with eff_credit[i]!=0, searching ptr, ptr+1, ... wrapping
//    NUM_REQ-1 -> 0. Grant registered: req sampled cycle N -> gnt_vld/gnt/gnt_id cycle N+1.
//  - On grant to i: credit[i] <= eff_credit[i]-1; other credits <= eff_credit;
//    ptr <= i if eff_credit[i]>1 (stay for burst) else (i+1) mod NUM_REQ (wrap).
//  - Requester dropping req mid-burst: its leftover credit is kept but skipped; ptr
//    advances past it on next search; leftover spent only if it re-requests in-round.
//  - No eligible requester: gnt_vld=0, gnt=0, gnt_id holds last, credit/ptr unchanged.
//  - prio_upt (prio_id<NUM_REQ): weight[prio_id]<=prio and credit[prio_id]<=prio next
//    cycle. Same-cycle grant to same id: update wins for credit (grant decrement lost).
//    Updated weight affects selection from the cycle after the write.
//  - Credits never underflow; all pointer/index arithmetic modulo NUM_REQ.
// CONFIGURATION
//  WRR_LOCK_EN defined: adds input gnt_lock (1 bit). While gnt_lock=1 and gnt_vld=1
//    with req[gnt_id]=1, next cycle re-grants gnt_id without consuming credit and
//    without moving ptr; prio_upt still applies. Lock released when gnt_lock=0 or
//    req[gnt_id] drops; normal selection resumes that cycle.
//  WRR_LOCK_EN undefined: no gnt_lock port; every grant consumes one credit.
// TESTING
//  1. Reset, req=0x7 held, no updates -> gnt_id 0,1,2,0,1,2..., gnt_vld=1 from cycle 2.
//  2. weight0=3, weight1=1, req=0x3 held -> gnt_id 0,0,0,1,0,0,0,1 (reload, no bubble).
//  3. weight5=0, req=0x20 only -> gnt_vld=0 forever; then set weight5=2 -> gnt_id=5
//     two cycles after prio_upt, then every cycle (reload each round).
//  4. weight0=4, req=0x3; drop req[0] after 2 grants -> next gnt_id=1; prio_upt id=40?
//     use id=31 with NUM_REQ=32 legal; id beyond NUM_REQ (NUM_REQ=8, id=9) -> no change.
//  5. Assert rst mid-burst (weight0=4 after 2 grants) -> gnt_vld=0 next cycle, then
//     plain round robin from id 0 with all weights=1.
//  6. WRR_LOCK_EN: weight2=1, req=0x6, gnt_lock=1 while gnt_id=2 for 5 cycles -> gnt_id=2
//     x5; release -> gnt_id=1 next, credits of 1 and 2 unchanged by locked cycles.

Source files
------------

// File: rtl/wrr_if.sv
// wrr_if: request, priority-update and grant bundle for wrr_weight_scheduler.
// The gnt_lock signal exists only when WRR_LOCK_EN is defined.
interface wrr_if #(
  parameter int NUM_REQ = 32,
  parameter int WEIGHT_W = 4
);
  logic [NUM_REQ-1:0] req;
  logic [WEIGHT_W-1:0] prio;
  logic [4:0] prio_id;
  logic prio_upt;
  logic [NUM_REQ-1:0] gnt;
  logic [4:0] gnt_id;
  logic gnt_vld;
`ifdef WRR_LOCK_EN
  logic gnt_lock;
  modport master (output req, prio, prio_id, prio_upt, gnt_lock, input gnt, gnt_id, gnt_vld);
  modport slave (input req, prio, prio_id, prio_upt, gnt_lock, output gnt, gnt_id, gnt_vld);
`else
  modport master (output req, prio, prio_id, prio_upt, input gnt, gnt_id, gnt_vld);
  modport slave (input req, prio, prio_id, prio_upt, output gnt, gnt_id, gnt_vld);
`endif
endinterface

// File: rtl/wrr_weight_scheduler.sv
// wrr_weight_scheduler: weighted round-robin grant scheduler with a per-requester weight table.
// Define WRR_LOCK_EN to add gnt_lock, which re-grants the current holder without spending credit.
module wrr_weight_scheduler #(
  parameter int NUM_REQ = 32,
  parameter int WEIGHT_W = 4,
  parameter int WEIGHT_RST = 1
) (
  input logic clk,
  input logic rst,
  wrr_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [WEIGHT_W-1:0] weight [NUM_REQ];
  logic [WEIGHT_W-1:0] credit [NUM_REQ];
  logic [WEIGHT_W-1:0] eff [NUM_REQ];
  logic [NUM_REQ-1:0] elig, has_cred;
  logic [IW-1:0] ptr, sel, ptr_nxt, jx;
  logic found, reload, hold, upt;
`ifdef WRR_LOCK_EN
  logic [IW-1:0] gnt_idx;
  assign gnt_idx = bus.gnt_id[IW-1:0];
  assign hold = bus.gnt_lock && bus.gnt_vld && bus.req[gnt_idx];
`else
  assign hold = 1'b0;
`endif
  assign upt = bus.prio_upt && int'(bus.prio_id) < NUM_REQ;
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req[i] && weight[i] != '0;
      has_cred[i] = elig[i] && credit[i] != '0;
    end
    // reload in the same cycle as the grant so a new round starts without a bubble
    reload = ~|has_cred && |elig;
    for (int i = 0; i < NUM_REQ; i++) eff[i] = reload ? weight[i] : credit[i];
    found = 1'b0;
    sel = ptr;
    jx = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      jx = IW'(int'(ptr) + k >= NUM_REQ ? int'(ptr) + k - NUM_REQ : int'(ptr) + k);
      if (!found && elig[jx] && eff[jx] != '0) begin
        found = 1'b1;
        sel = jx;
      end
    end
    ptr_nxt = eff[sel] > WEIGHT_W'(1) ? sel : sel == IW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        weight[i] <= WEIGHT_W'(WEIGHT_RST);
        credit[i] <= WEIGHT_W'(WEIGHT_RST);
      end
      ptr <= '0;
      bus.gnt <= '0;
      bus.gnt_id <= '0;
      bus.gnt_vld <= 1'b0;
    end else begin
      bus.gnt_vld <= hold || found;
      bus.gnt <= hold ? bus.gnt : found ? NUM_REQ'(1) << sel : '0;
      if (!hold && found) begin
        bus.gnt_id <= 5'(sel);
        ptr <= ptr_nxt;
        for (int i = 0; i < NUM_REQ; i++) credit[i] <= IW'(i) == sel ? eff[i] - 1'b1 : eff[i];
      end
      // a weight write also overwrites any same-cycle credit decrement
      if (upt) begin
        weight[bus.prio_id[IW-1:0]] <= bus.prio;
        credit[bus.prio_id[IW-1:0]] <= bus.prio;
      end
    end
  end
endmodule

// File: tb/tb_wrr_weight_scheduler.sv
// tb_wrr_weight_scheduler: directed scenarios plus randomized traffic against a behavioural WRR model.
// Builds with or without WRR_LOCK_EN.
module tb_wrr_weight_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  wrr_if #(.NUM_REQ(32)) ifa ();
  wrr_if #(.NUM_REQ(8)) ifb ();
  wrr_weight_scheduler dut_a (.clk(clk), .rst(rst), .bus(ifa));
  wrr_weight_scheduler #(.NUM_REQ(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ifa.req = '0; ifa.prio = '0; ifa.prio_id = '0; ifa.prio_upt = 1'b0;
    ifb.req = '0; ifb.prio = '0; ifb.prio_id = '0; ifb.prio_upt = 1'b0;
`ifdef WRR_LOCK_EN
    ifa.gnt_lock = 1'b0;
    ifb.gnt_lock = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic upd_a(input int id, input int p);
    ifa.prio_id = 5'(id);
    ifa.prio = 4'(p);
    ifa.prio_upt = 1'b1;
    @(negedge clk);
    ifa.prio_upt = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    ifa.req = '1;
    ifa.prio_upt = 1'b1;
    @(negedge clk);
    checks++;
    if (ifa.gnt_vld !== 1'b0 || ifa.gnt !== '0 || ifa.gnt_id !== 5'd0) begin
      errors++;
      $display("FAIL reset: vld=%0b gnt=%h id=%0d expected 0/0/0", ifa.gnt_vld, ifa.gnt, ifa.gnt_id);
    end
    rst = 1'b0;
    ifa.prio_upt = 1'b0;
    ifa.req = 32'h1;
    @(negedge clk);
    checks++;
    if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'd0) begin
      errors++;
      $display("FAIL reset_upt_ignored: vld=%0b id=%0d expected 1/0", ifa.gnt_vld, ifa.gnt_id);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ifa.req = 32'h7;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'(k % 3) || ifa.gnt !== 32'(1) << (k % 3)) begin
        errors++;
        $display("FAIL rr[%0d]: vld=%0b id=%0d gnt=%h expected id=%0d", k, ifa.gnt_vld, ifa.gnt_id, ifa.gnt, k % 3);
      end
    end
  endtask

  task automatic test_weights();
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    upd_a(0, 3);
    ifa.req = 32'h3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'(exp_seq[k])) begin
        errors++;
        $display("FAIL weights[%0d]: vld=%0b id=%0d expected id=%0d", k, ifa.gnt_vld, ifa.gnt_id, exp_seq[k]);
      end
    end
  endtask

  task automatic test_mask();
    do_reset();
    upd_a(5, 0);
    ifa.req = 32'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== 1'b0 || ifa.gnt !== '0) begin
        errors++;
        $display("FAIL mask[%0d]: vld=%0b gnt=%h expected idle", k, ifa.gnt_vld, ifa.gnt);
      end
    end
    upd_a(5, 2);
    checks++;
    if (ifa.gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL mask_write_cycle: vld=%0b expected 0", ifa.gnt_vld);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'd5 || ifa.gnt !== 32'h20) begin
        errors++;
        $display("FAIL unmask[%0d]: vld=%0b id=%0d expected 1/5", k, ifa.gnt_vld, ifa.gnt_id);
      end
    end
  endtask

  task automatic test_drop();
    int exp_seq [3] = '{0, 0, 1};
    do_reset();
    upd_a(0, 4);
    ifa.req = 32'h3;
    repeat (2) @(negedge clk);
    ifa.req = 32'h2;
    @(negedge clk);
    checks++;
    if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'd1) begin
      errors++;
      $display("FAIL drop: vld=%0b id=%0d expected id=1", ifa.gnt_vld, ifa.gnt_id);
    end
    ifa.req = 32'h3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_id !== 5'(exp_seq[k])) begin
        errors++;
        $display("FAIL leftover[%0d]: id=%0d expected id=%0d", k, ifa.gnt_id, exp_seq[k]);
      end
    end
    ifa.req = '0;
    upd_a(31, 2);
    ifa.req = 32'h8000_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'd31 || ifa.gnt !== 32'h8000_0000) begin
        errors++;
        $display("FAIL id31[%0d]: vld=%0b id=%0d gnt=%h expected id=31", k, ifa.gnt_vld, ifa.gnt_id, ifa.gnt);
      end
    end
  endtask

  task automatic test_bad_id();
    do_reset();
    for (int id = 8; id < 10; id++) begin
      ifb.prio_id = 5'(id);
      ifb.prio = 4'd0;
      ifb.prio_upt = 1'b1;
      @(negedge clk);
    end
    ifb.prio_upt = 1'b0;
    ifb.req = 8'h3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ifb.gnt_vld !== 1'b1 || ifb.gnt_id !== 5'(k % 2)) begin
        errors++;
        $display("FAIL bad_id[%0d]: vld=%0b id=%0d expected id=%0d", k, ifb.gnt_vld, ifb.gnt_id, k % 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    upd_a(0, 4);
    ifa.req = 32'h3;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifa.gnt_vld !== 1'b0 || ifa.gnt !== '0 || ifa.gnt_id !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: vld=%0b gnt=%h id=%0d expected 0/0/0", ifa.gnt_vld, ifa.gnt, ifa.gnt_id);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'(k % 2)) begin
        errors++;
        $display("FAIL after_reset[%0d]: vld=%0b id=%0d expected id=%0d", k, ifa.gnt_vld, ifa.gnt_id, k % 2);
      end
    end
  endtask

`ifdef WRR_LOCK_EN
  task automatic test_lock();
    int exp_seq [2] = '{1, 2};
    do_reset();
    ifa.req = 32'h6;
    repeat (2) @(negedge clk);
    ifa.gnt_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== 1'b1 || ifa.gnt_id !== 5'd2) begin
        errors++;
        $display("FAIL lock[%0d]: vld=%0b id=%0d expected id=2", k, ifa.gnt_vld, ifa.gnt_id);
      end
    end
    ifa.gnt_lock = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.gnt_id !== 5'(exp_seq[k])) begin
        errors++;
        $display("FAIL unlock[%0d]: id=%0d expected id=%0d", k, ifa.gnt_id, exp_seq[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int mw [32], mc [32], ef [32];
    int mp, mid, sel, id, p;
    bit mv, any, cred, lock, up;
    logic [31:0] r;
    do_reset();
    foreach (mw[i]) begin mw[i] = 1; mc[i] = 1; end
    mp = 0; mid = 0; mv = 0;
    repeat (600) begin
      r = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom & $urandom & $urandom;
      up = $urandom_range(0, 5) == 0;
      id = $urandom_range(0, 31);
      p = $urandom_range(0, 15);
      lock = 0;
`ifdef WRR_LOCK_EN
      ifa.gnt_lock = $urandom_range(0, 2) == 0;
      lock = ifa.gnt_lock && mv && r[mid];
`endif
      ifa.req = r; ifa.prio_upt = up; ifa.prio_id = 5'(id); ifa.prio = 4'(p);
      if (!lock) begin
        any = 0; cred = 0;
        for (int i = 0; i < 32; i++) begin
          any |= r[i] && mw[i] != 0;
          cred |= r[i] && mw[i] != 0 && mc[i] != 0;
        end
        for (int i = 0; i < 32; i++) ef[i] = (any && !cred) ? mw[i] : mc[i];
        sel = -1;
        for (int k = 0; k < 32; k++)
          if (sel < 0 && r[(mp + k) % 32] && mw[(mp + k) % 32] != 0 && ef[(mp + k) % 32] != 0) sel = (mp + k) % 32;
        mv = sel >= 0;
        if (mv) begin
          mc = ef;
          mc[sel]--;
          mp = ef[sel] > 1 ? sel : (sel + 1) % 32;
          mid = sel;
        end
      end
      if (up) begin mw[id] = p; mc[id] = p; end
      @(negedge clk);
      checks++;
      if (ifa.gnt_vld !== mv || ifa.gnt_id !== 5'(mid) || ifa.gnt !== (mv ? 32'(1) << mid : 32'h0)) begin
        errors++;
        $display("FAIL random: vld=%0b id=%0d gnt=%h expected vld=%0b id=%0d", ifa.gnt_vld, ifa.gnt_id, ifa.gnt, mv, mid);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weights();
    test_mask();
    test_drop();
    test_bad_id();
    test_reset_mid();
`ifdef WRR_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
